// File: rtl/adder_result_display_if.sv
// Bundle of the adder-side inputs and the display-side outputs of the
// adder result display. The master side (adder stage / bench) drives the
// operands and the capture strobe; the slave side (the display block)
// drives the captured result and the multiplexed 7-segment lines.
interface adder_result_display_if;
    logic [3:0] F;
    logic       C4;
    logic       load;
    logic       valid;
    logic [4:0] result;
    logic [7:0] seg;
    logic [1:0] an;

    modport master (
        output F, C4, load,
        input  valid, result, seg, an
    );

    modport slave (
        input  F, C4, load,
        output valid, result, seg, an
    );
endinterface

// File: rtl/adder_result_display.sv
// Captures {C4,F} from the 4-bit adder on a load strobe, converts the
// 5-bit result to two decimal digits and drives a two-digit multiplexed
// 7-segment display. The ones-digit decimal point shows the carry flag.
module adder_result_display #(
    parameter int SCAN_DIV       = 50000,
    parameter bit SEG_ACTIVE_LOW = 1'b1
) (
    input  logic                  clk,
    input  logic                  rst,
    adder_result_display_if.slave bus
);

    localparam int         CW        = (SCAN_DIV > 2) ? $clog2(SCAN_DIV) : 1;
    localparam logic [CW-1:0] SCAN_LAST = CW'(SCAN_DIV - 1);
    localparam logic [7:0] SEG_OFF   = SEG_ACTIVE_LOW ? 8'hFF : 8'h00;
    localparam logic [1:0] AN_OFF    = SEG_ACTIVE_LOW ? 2'b11 : 2'b00;

    // Active-low segment pattern {dp,g,f,e,d,c,b,a} for a decimal digit, dp off.
    function automatic logic [7:0] seg_code(input logic [3:0] d);
        logic [7:0] p;
        case (d)
            4'd0:    p = 8'hC0;
            4'd1:    p = 8'hF9;
            4'd2:    p = 8'hA4;
            4'd3:    p = 8'hB0;
            4'd4:    p = 8'h99;
            4'd5:    p = 8'h92;
            4'd6:    p = 8'h82;
            4'd7:    p = 8'hF8;
            4'd8:    p = 8'h80;
            4'd9:    p = 8'h90;
            default: p = 8'hFF;
        endcase
        return p;
    endfunction

    // Tens digit of a 0..31 value, done with compares instead of a divider.
    function automatic logic [1:0] tens_of(input logic [4:0] v);
        logic [1:0] t;
        if (v >= 5'd30)      t = 2'd3;
        else if (v >= 5'd20) t = 2'd2;
        else if (v >= 5'd10) t = 2'd1;
        else                 t = 2'd0;
        return t;
    endfunction

    // Ones digit of a 0..31 value: subtract the tens part found above.
    function automatic logic [3:0] ones_of(input logic [4:0] v);
        logic [4:0] r;
        case (tens_of(v))
            2'd3:    r = v - 5'd30;
            2'd2:    r = v - 5'd20;
            2'd1:    r = v - 5'd10;
            default: r = v;
        endcase
        return r[3:0];
    endfunction

    logic [4:0]    result_q;
    logic          valid_q;
    logic [1:0]    tens_q;
    logic [3:0]    ones_q;
    logic          dp_q;
    logic          disp_valid_q;
    logic [CW-1:0] scan_cnt_q, scan_cnt_d;
    logic          digit_sel_q, digit_sel_d;
    logic [7:0]    seg_q, seg_d;
    logic [1:0]    an_q, an_d;

    // Capture the adder result on the load strobe; valid sticks once set.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            result_q <= 5'd0;
            valid_q  <= 1'b0;
        end else if (bus.load) begin
            result_q <= {bus.C4, bus.F};
            valid_q  <= 1'b1;
        end else begin
            result_q <= result_q;
            valid_q  <= valid_q;
        end
    end

    // Decimal conversion registered one cycle behind the result, with valid
    // delayed alongside so the dash/number choice matches the digit contents.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            tens_q       <= 2'd0;
            ones_q       <= 4'd0;
            dp_q         <= 1'b0;
            disp_valid_q <= 1'b0;
        end else begin
            tens_q       <= tens_of(result_q);
            ones_q       <= ones_of(result_q);
            dp_q         <= result_q[4];
            disp_valid_q <= valid_q;
        end
    end

    // Next state of the free-running slot counter and digit select.
    always_comb begin
        scan_cnt_d  = scan_cnt_q;
        digit_sel_d = digit_sel_q;
        if (scan_cnt_q == SCAN_LAST) begin
            scan_cnt_d  = {CW{1'b0}};
            digit_sel_d = ~digit_sel_q;
        end else begin
            scan_cnt_d  = scan_cnt_q + CW'(1);
            digit_sel_d = digit_sel_q;
        end
    end

    // Scan state registers; captures never touch them.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            scan_cnt_q  <= {CW{1'b0}};
            digit_sel_q <= 1'b0;
        end else begin
            scan_cnt_q  <= scan_cnt_d;
            digit_sel_q <= digit_sel_d;
        end
    end

    // Pattern and enable for the digit currently selected (0 = ones, 1 = tens).
    always_comb begin
        seg_d = 8'hFF;
        an_d  = 2'b11;
        if (!disp_valid_q) begin
            seg_d = 8'hBF;
        end else if (!digit_sel_q) begin
            seg_d = seg_code(ones_q) & (dp_q ? 8'h7F : 8'hFF);
        end else if (tens_q == 2'd0) begin
            seg_d = 8'hFF;
        end else begin
            seg_d = seg_code({2'b00, tens_q});
        end
        if (!digit_sel_q) begin
            an_d = 2'b10;
        end else begin
            an_d = 2'b01;
        end
        if (!SEG_ACTIVE_LOW) begin
            seg_d = ~seg_d;
            an_d  = ~an_d;
        end else begin
            seg_d = seg_d;
            an_d  = an_d;
        end
    end

    // Registered display outputs: seg and an update on the same edge, and the
    // select is used one edge late so the first slot after reset is full length.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            seg_q <= SEG_OFF;
            an_q  <= AN_OFF;
        end else begin
            seg_q <= seg_d;
            an_q  <= an_d;
        end
    end

    assign bus.valid  = valid_q;
    assign bus.result = result_q;
    assign bus.seg    = seg_q;
    assign bus.an     = an_q;

endmodule

// File: tb/tb_adder_result_display.sv
// Directed bench for adder_result_display with SCAN_DIV = 4, active-low display.
module tb_adder_result_display;

    logic clk;
    logic rst;
    int   n_checks;
    int   n_fail;

    adder_result_display_if bus_if ();

    adder_result_display #(
        .SCAN_DIV       (4),
        .SEG_ACTIVE_LOW (1'b1)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus_if)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic test_reset();
        rst = 1'b0;
        bus_if.load = 1'b0;
        bus_if.F    = 4'd0;
        bus_if.C4   = 1'b0;
        repeat (2) @(negedge clk);
        #2 rst = 1'b1;
        #1;
        n_checks++; if (bus_if.an !== 2'b11) begin n_fail++; $display("FAIL reset_an: got %b want 11", bus_if.an); end
        n_checks++; if (bus_if.seg !== 8'hFF) begin n_fail++; $display("FAIL reset_seg: got %h want ff", bus_if.seg); end
        n_checks++; if (bus_if.valid !== 1'b0) begin n_fail++; $display("FAIL reset_valid: got %b want 0", bus_if.valid); end
        n_checks++; if (bus_if.result !== 5'd0) begin n_fail++; $display("FAIL reset_result: got %0d want 0", bus_if.result); end
        repeat (3) @(negedge clk);
        n_checks++; if (bus_if.an !== 2'b11 || bus_if.seg !== 8'hFF) begin n_fail++; $display("FAIL reset_hold: an %b seg %h want 11 ff", bus_if.an, bus_if.seg); end
    endtask

    task automatic test_scan();
        logic [1:0] exp_an;
        @(negedge clk);
        rst = 1'b0;
        for (int k = 1; k <= 12; k++) begin
            @(posedge clk); #1;
            exp_an = ((((k - 1) / 4) % 2) == 0) ? 2'b10 : 2'b01;
            n_checks++; if (bus_if.an !== exp_an) begin n_fail++; $display("FAIL scan_an k=%0d: got %b want %b", k, bus_if.an, exp_an); end
            n_checks++; if (bus_if.seg !== 8'hBF) begin n_fail++; $display("FAIL scan_dash k=%0d: got %h want bf", k, bus_if.seg); end
        end
        n_checks++; if (bus_if.valid !== 1'b0) begin n_fail++; $display("FAIL scan_valid: got %b want 0", bus_if.valid); end
    endtask

    task automatic test_capture(input logic [3:0] f, input logic c4, input logic [4:0] exp_res,
                                input logic [7:0] exp_ones, input logic [7:0] exp_tens);
        @(negedge clk);
        bus_if.F = f; bus_if.C4 = c4; bus_if.load = 1'b1;
        @(posedge clk); #1;
        n_checks++; if (bus_if.result !== exp_res) begin n_fail++; $display("FAIL cap_result: got %0d want %0d", bus_if.result, exp_res); end
        n_checks++; if (bus_if.valid !== 1'b1) begin n_fail++; $display("FAIL cap_valid: got %b want 1", bus_if.valid); end
        @(negedge clk);
        bus_if.load = 1'b0;
        bus_if.F = 4'd0; bus_if.C4 = 1'b0;
        repeat (2) @(posedge clk);
        for (int k = 0; k < 8; k++) begin
            @(posedge clk); #1;
            n_checks++;
            if (bus_if.an === 2'b10) begin
                if (bus_if.seg !== exp_ones) begin n_fail++; $display("FAIL cap_ones r=%0d: got %h want %h", exp_res, bus_if.seg, exp_ones); end
            end else if (bus_if.an === 2'b01) begin
                if (bus_if.seg !== exp_tens) begin n_fail++; $display("FAIL cap_tens r=%0d: got %h want %h", exp_res, bus_if.seg, exp_tens); end
            end else begin
                n_fail++; $display("FAIL cap_an r=%0d: got %b want 10 or 01", exp_res, bus_if.an);
            end
        end
        n_checks++; if (bus_if.result !== exp_res) begin n_fail++; $display("FAIL cap_hold: got %0d want %0d", bus_if.result, exp_res); end
    endtask

    task automatic test_load_held();
        logic [7:0] codes [10];
        logic [7:0] exp_o, exp_t;
        int r;
        codes = '{8'hC0, 8'hF9, 8'hA4, 8'hB0, 8'h99, 8'h92, 8'h82, 8'hF8, 8'h80, 8'h90};
        for (int i = 0; i <= 17; i++) begin
            @(negedge clk);
            if (i <= 15) begin
                bus_if.F = 4'(i); bus_if.C4 = 1'b0; bus_if.load = 1'b1;
            end else begin
                bus_if.load = 1'b0;
            end
            @(posedge clk); #1;
            if (i <= 15) begin
                n_checks++; if (bus_if.result !== 5'(i)) begin n_fail++; $display("FAIL held_result i=%0d: got %0d want %0d", i, bus_if.result, i); end
            end
            if (i >= 2) begin
                r = i - 2;
                exp_o = codes[r % 10];
                exp_t = (r >= 10) ? 8'hF9 : 8'hFF;
                n_checks++;
                if (bus_if.an === 2'b10) begin
                    if (bus_if.seg !== exp_o) begin n_fail++; $display("FAIL held_ones r=%0d: got %h want %h", r, bus_if.seg, exp_o); end
                end else if (bus_if.an === 2'b01) begin
                    if (bus_if.seg !== exp_t) begin n_fail++; $display("FAIL held_tens r=%0d: got %h want %h", r, bus_if.seg, exp_t); end
                end else begin
                    n_fail++; $display("FAIL held_an r=%0d: got %b", r, bus_if.an);
                end
            end
        end
    endtask

    task automatic test_reset_mid_and_wrap_load();
        logic [1:0] exp_an;
        logic [7:0] exp_seg;
        test_capture(4'b0110, 1'b1, 5'd22, 8'h24, 8'hA4);
        @(negedge clk);
        @(negedge clk);
        #2 rst = 1'b1;
        #1;
        n_checks++; if (bus_if.an !== 2'b11) begin n_fail++; $display("FAIL mid_rst_an: got %b want 11", bus_if.an); end
        n_checks++; if (bus_if.seg !== 8'hFF) begin n_fail++; $display("FAIL mid_rst_seg: got %h want ff", bus_if.seg); end
        n_checks++; if (bus_if.valid !== 1'b0 || bus_if.result !== 5'd0) begin n_fail++; $display("FAIL mid_rst_state: valid %b result %0d want 0 0", bus_if.valid, bus_if.result); end
        @(negedge clk);
        rst = 1'b0;
        for (int k = 1; k <= 12; k++) begin
            bus_if.load = (k == 4) ? 1'b1 : 1'b0;
            bus_if.F = 4'd7; bus_if.C4 = 1'b0;
            @(posedge clk); #1;
            exp_an = (k <= 4 || k >= 9) ? 2'b10 : 2'b01;
            if (k <= 5)      exp_seg = 8'hBF;
            else if (k <= 8) exp_seg = 8'hFF;
            else             exp_seg = 8'hF8;
            n_checks++; if (bus_if.an !== exp_an) begin n_fail++; $display("FAIL restart_an k=%0d: got %b want %b", k, bus_if.an, exp_an); end
            n_checks++; if (bus_if.seg !== exp_seg) begin n_fail++; $display("FAIL restart_seg k=%0d: got %h want %h", k, bus_if.seg, exp_seg); end
            if (k == 1) begin
                n_checks++; if (bus_if.valid !== 1'b0) begin n_fail++; $display("FAIL restart_valid: got %b want 0", bus_if.valid); end
            end
            if (k == 4) begin
                n_checks++; if (bus_if.result !== 5'd7 || bus_if.valid !== 1'b1) begin n_fail++; $display("FAIL wrap_load: result %0d valid %b want 7 1", bus_if.result, bus_if.valid); end
            end
            @(negedge clk);
        end
        bus_if.load = 1'b0;
    endtask

    initial begin
        n_checks = 0;
        n_fail   = 0;
        test_reset();
        test_scan();
        test_capture(4'b1001, 1'b0, 5'd9, 8'h90, 8'hFF);
        test_capture(4'b1111, 1'b1, 5'd31, 8'h79, 8'hB0);
        test_capture(4'b0000, 1'b0, 5'd0, 8'hC0, 8'hFF);
        test_load_held();
        test_reset_mid_and_wrap_load();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
